// File: rtl/button_conditioner_pkg.sv
// Shared constants for the button conditioner: debounce FSM state encoding,
// stability-counter width and the debounce-window helper.
package button_conditioner_pkg;

  localparam int unsigned     DB_CNT_W   = 24;
  localparam longint unsigned DB_CNT_MAX = (64'd1 << DB_CNT_W) - 64'd1;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } db_state_e;

  // Number of consecutive stable samples a debounce window spans.
  function automatic longint unsigned db_cycles(input longint unsigned clk_freq,
                                                input longint unsigned debounce_ms);
    return (clk_freq / 64'd1000) * debounce_ms;
  endfunction

endpackage

// File: rtl/button_conditioner_debounce.sv
// One debounce channel: 2-flop synchroniser, polarity normalisation,
// IDLE/PRESS_WAIT/PRESSED/RELEASE_WAIT FSM with a 24-bit stability counter.
// Ports:
//   clk, rst  : system clock, async active-high reset
//   btn_raw   : unsynchronised button input
//   level     : next-cycle debounced pressed level (registered by the parent)
//   pulse     : high on the edge that completes an IDLE->PRESSED traversal
//               (registered by the parent)
module debounce_channel
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DB_CYCLES  = 4,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic pulse
);

  localparam logic                RELEASED = ACTIVE_LOW;
  localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DB_CYCLES - 1);

  logic                sync1_q, sync2_q;
  logic                pressed;
  db_state_e           state_q, state_d;
  logic [DB_CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= RELEASED;
      sync2_q <= RELEASED;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pressed = sync2_q ^ ACTIVE_LOW;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pressed) begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!pressed) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_PRESSED;
          pulse   = 1'b1;
        end else begin
          cnt_d = cnt_q + DB_CNT_W'(1);
        end
      end
      ST_PRESSED: begin
        if (!pressed) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      ST_RELEASE_WAIT: begin
        if (pressed) begin
          state_d = ST_PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + DB_CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Level follows the next state so the parent's output register lines up
  // with the pulse on the same edge.
  assign level = (state_d == ST_PRESSED) || (state_d == ST_RELEASE_WAIT);

endmodule

// File: rtl/button_conditioner.sv
// Conditions the stopwatch start/stop and reset buttons: two debounce
// channels, reset-over-start priority, registered outputs.
// Ports:
//   clk, rst        : system clock, async active-high reset
//   btn_start_raw   : unsynchronised start/stop button
//   btn_reset_raw   : unsynchronised reset button
//   start_stop      : one-cycle pulse per confirmed start/stop press
//   reset           : one-cycle pulse per confirmed reset press
//   btn_start_level : debounced pressed level, start button
//   btn_reset_level : debounced pressed level, reset button
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int unsigned CLK_FREQ       = 50_000_000,
  parameter int unsigned DEBOUNCE_MS    = 10,
  parameter int unsigned BTN_ACTIVE_LOW = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_start_raw,
  input  logic btn_reset_raw,
  output logic start_stop,
  output logic reset,
  output logic btn_start_level,
  output logic btn_reset_level
);

  localparam longint unsigned DB_CYCLES =
    db_cycles(64'(CLK_FREQ), 64'(DEBOUNCE_MS));

  if (DB_CYCLES < 64'd2 || DB_CYCLES > DB_CNT_MAX) begin : g_bad_db_cycles
    $error("button_conditioner: debounce window out of range");
  end

  logic start_level, start_pulse;
  logic reset_level, reset_pulse;

  logic start_stop_q, start_stop_d;
  logic reset_q, reset_d;
  logic start_level_q, reset_level_q;

  debounce_channel #(
    .DB_CYCLES (32'(DB_CYCLES)),
    .ACTIVE_LOW(BTN_ACTIVE_LOW != 0)
  ) u_start (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(btn_start_raw),
    .level  (start_level),
    .pulse  (start_pulse)
  );

  debounce_channel #(
    .DB_CYCLES (32'(DB_CYCLES)),
    .ACTIVE_LOW(BTN_ACTIVE_LOW != 0)
  ) u_reset (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(btn_reset_raw),
    .level  (reset_level),
    .pulse  (reset_pulse)
  );

  // A coincident start pulse is dropped outright; reset wins.
  always_comb begin
    reset_d      = reset_pulse;
    start_stop_d = start_pulse & ~reset_pulse;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_stop_q  <= 1'b0;
      reset_q       <= 1'b0;
      start_level_q <= 1'b0;
      reset_level_q <= 1'b0;
    end else begin
      start_stop_q  <= start_stop_d;
      reset_q       <= reset_d;
      start_level_q <= start_level;
      reset_level_q <= reset_level;
    end
  end

  assign start_stop      = start_stop_q;
  assign reset           = reset_q;
  assign btn_start_level = start_level_q;
  assign btn_reset_level = reset_level_q;

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, system clock in Hz.
REQ-002 SHALL have parameter DEBOUNCE_MS, default 10, stable-time window in ms.
REQ-003 SHALL have parameter BTN_ACTIVE_LOW, default 0; when 1, raw inputs are pressed when low.
REQ-004 SHALL have port clk  input  1  single system clock, all logic on posedge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port btn_start_raw  input  1  unsynchronised start/stop button.
REQ-007 SHALL have port btn_reset_raw  input  1  unsynchronised reset button.
REQ-008 SHALL have port start_stop  output  1  one-cycle pulse per confirmed start/stop press; drives stopwatch start_stop.
REQ-009 SHALL have port reset  output  1  one-cycle pulse per confirmed reset press; drives stopwatch reset.
REQ-010 SHALL have port btn_start_level  output  1  debounced pressed level, start button.
REQ-011 SHALL have port btn_reset_level  output  1  debounced pressed level, reset button.

Function
REQ-012 DB_CYCLES SHALL equal (CLK_FREQ/1000)*DEBOUNCE_MS; elaboration SHALL fail if DB_CYCLES < 2 or > 2^24-1.
REQ-013 Each raw input SHALL pass through a 2-flop synchroniser, then be normalised to pressed=1 per BTN_ACTIVE_LOW.
REQ-014 Each channel SHALL run an FSM with states IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT and a 24-bit stability counter.
REQ-015 IDLE: pressed sample -> PRESS_WAIT, counter=0; else stay.
REQ-016 PRESS_WAIT: released sample -> IDLE, counter cleared; pressed sample with counter==DB_CYCLES-1 -> PRESSED with pulse; otherwise counter+1.
REQ-017 PRESSED: released sample -> RELEASE_WAIT, counter=0; else stay.
REQ-018 RELEASE_WAIT: pressed sample -> PRESSED, no pulse; released sample with counter==DB_CYCLES-1 -> IDLE; otherwise counter+1.
REQ-019 Level output SHALL be 1 in PRESSED and RELEASE_WAIT, 0 otherwise; registered.
REQ-020 Pulse outputs SHALL be registered and high for exactly one cycle per IDLE->PRESSED traversal; release SHALL never pulse.
REQ-021 Latency: raw press first sampled at edge 0 and held, pulse SHALL be high in the cycle after edge DB_CYCLES+2, no jitter.
REQ-022 Glitches shorter than DB_CYCLES samples SHALL produce no pulse and no level change.
REQ-023 If both channels would pulse in the same cycle, reset SHALL pulse and start_stop SHALL be suppressed (dropped, not delayed).
REQ-024 Held button SHALL yield exactly one pulse regardless of hold duration; counter SHALL not wrap.

Reset
REQ-025 rst SHALL asynchronously force synchroniser flops to the released level, FSMs to IDLE, counters to 0, all four outputs to 0.
REQ-026 Reset mid-debounce SHALL discard partial counts; a button held through rst deassertion SHALL be treated as a new press (pulse after DB_CYCLES+2 edges).

Structure
REQ-027 FSM state encodings and counter width (24) SHALL live in the shared stopwatch constants package/header.
REQ-028 One sub-module debounce_channel (synchroniser + FSM + counter, outputs level and pulse) SHALL be instantiated twice; top holds priority logic and output registers.

Verification
REQ-029 CLK_FREQ=1000, DEBOUNCE_MS=4 (DB_CYCLES=4): start held 20 cycles -> start_stop high exactly one cycle after edge 6, btn_start_level high from same cycle until 4+2 edges after release.
REQ-030 Start bounce 1,0,1,0 at 1-cycle spacing then held -> single pulse, 6 edges after final rising sample.
REQ-031 3-cycle glitch on reset button -> no reset pulse, btn_reset_level stays 0.
REQ-032 Both buttons pressed on same edge, held 10 cycles -> reset pulses once, start_stop stays 0 throughout.
REQ-033 rst asserted at PRESS_WAIT count 2 with button held, released -> outputs 0 immediately, pulse 6 edges after rst deassertion.
REQ-034 BTN_ACTIVE_LOW=1, inputs idle high: after rst no pulse; input low 10 cycles -> one pulse with latency per REQ-021.
